// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder. It computes {c_out, sum} = a + b + c_in
// and adds DIGIT bits per clock, starting with the least significant digit.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   a, b and c_in are presented
//   in_ready   operands can be accepted (IDLE only)
//   a, b       WIDTH-bit operands
//   c_in       carry-in
//   out_valid  sum and c_out hold a completed result
//   out_ready  consumer takes the result
//   sum        registered WIDTH-bit result, modulo 2^WIDTH
//   c_out      registered carry-out of the full add
//   busy       high while an operation is in RUN or DONE
`timescale 1ns/1ps

module chunked_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             busy
);

   localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("chunked_adder: DIGIT (%0d) must be >= 1 and divide WIDTH (%0d)", DIGIT, WIDTH);
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_c_out;
   logic [CW-1:0]    r_cnt;

   logic [DIGIT-1:0] w_a_dig;
   logic [DIGIT-1:0] w_b_dig;
   logic [DIGIT:0]   w_dig_sum;
   logic [WIDTH-1:0] w_work_next;
   logic             w_last;

   assign w_last = (r_cnt == CW'(N - 1));

   // Digit slice selected by the counter, its add, and the working register
   // with that slice replaced. The loop keeps every part-select base constant.
   always_comb begin
      // NOTE: every signal gets a default before any conditional assignment,
      // so no path leaves it unassigned and no latch is inferred.
      w_a_dig     = '0;
      w_b_dig     = '0;
      for (int k = 0; k < N; k++) begin
         if (r_cnt == CW'(k)) begin
            w_a_dig = r_a[k*DIGIT +: DIGIT];
            w_b_dig = r_b[k*DIGIT +: DIGIT];
         end
      end
      w_dig_sum   = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
      w_work_next = r_work;
      for (int k = 0; k < N; k++) begin
         if (r_cnt == CW'(k)) begin
            w_work_next[k*DIGIT +: DIGIT] = w_dig_sum[DIGIT-1:0];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples values from before the edge, whatever the order.
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_next = S_RUN;
         S_RUN:   if (w_last)    w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default:                w_state_next = S_IDLE;
      endcase
   end

   // Output logic. Every output is decoded from the registered state.
   always_comb begin
      in_ready  = (r_state == S_IDLE);
      busy      = (r_state == S_RUN) || (r_state == S_DONE);
      out_valid = (r_state == S_DONE);
   end

   // Datapath. The last RUN edge is also the DONE entry edge, so sum takes
   // the working value with the final digit already merged in.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_work  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_c_out <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= c_in;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               r_work  <= w_work_next;
               r_carry <= w_dig_sum[DIGIT];
               if (w_last) begin
                  r_sum   <= w_work_next;
                  r_c_out <= w_dig_sum[DIGIT];
               end else begin
                  r_cnt   <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign sum   = r_sum;
   assign c_out = r_c_out;

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: self-checking bench for chunked_adder. It runs three
// configurations (8/2, 2/1 and 8/8) against an arithmetic reference model.
// One instance is active at a time and is selected by sel.
`timescale 1ns/1ps

module tb_chunked_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       c_in = 1'b0;
   int         sel = 0;

   int n_checks = 0;
   int n_errors = 0;

   // instance 0: WIDTH=8 DIGIT=2
   logic       in_ready0, out_valid0, c_out0, busy0;
   logic [7:0] sum0;
   // instance 1: WIDTH=2 DIGIT=1
   logic       in_ready1, out_valid1, c_out1, busy1;
   logic [1:0] sum1;
   // instance 2: WIDTH=8 DIGIT=8
   logic       in_ready2, out_valid2, c_out2, busy2;
   logic [7:0] sum2;

   logic       cur_in_ready, cur_out_valid, cur_c_out, cur_busy;
   logic [7:0] cur_sum;

   always #5 clk = ~clk;

   chunked_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid && (sel == 0)), .in_ready(in_ready0),
      .a(a), .b(b), .c_in(c_in),
      .out_valid(out_valid0), .out_ready(out_ready && (sel == 0)),
      .sum(sum0), .c_out(c_out0), .busy(busy0)
   );

   chunked_adder #(.WIDTH(2), .DIGIT(1)) u_dut_w2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid && (sel == 1)), .in_ready(in_ready1),
      .a(a[1:0]), .b(b[1:0]), .c_in(c_in),
      .out_valid(out_valid1), .out_ready(out_ready && (sel == 1)),
      .sum(sum1), .c_out(c_out1), .busy(busy1)
   );

   chunked_adder #(.WIDTH(8), .DIGIT(8)) u_dut_n1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid && (sel == 2)), .in_ready(in_ready2),
      .a(a), .b(b), .c_in(c_in),
      .out_valid(out_valid2), .out_ready(out_ready && (sel == 2)),
      .sum(sum2), .c_out(c_out2), .busy(busy2)
   );

   always_comb begin
      cur_in_ready  = in_ready0;
      cur_out_valid = out_valid0;
      cur_c_out     = c_out0;
      cur_busy      = busy0;
      cur_sum       = sum0;
      case (sel)
         1: begin
            cur_in_ready = in_ready1; cur_out_valid = out_valid1;
            cur_c_out = c_out1; cur_busy = busy1; cur_sum = {6'b0, sum1};
         end
         2: begin
            cur_in_ready = in_ready2; cur_out_valid = out_valid2;
            cur_c_out = c_out2; cur_busy = busy2; cur_sum = sum2;
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
      end
   endtask

   // Advance one clock edge; inputs are driven and outputs sampled 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int width_of(input int s);
      return (s == 1) ? 2 : 8;
   endfunction

   function automatic int cycles_of(input int s);
      case (s)
         0:       return 4;
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   // Reference: one add at WIDTH+1 bits, then split into carry and sum.
   task automatic model(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        output logic [7:0] e_sum, output logic e_cout);
      logic [8:0] full;
      logic [7:0] mask;
      mask   = (width_of(sel) == 8) ? 8'hFF : 8'h03;
      full   = {1'b0, ta & mask} + {1'b0, tb_v & mask} + {8'b0, tc};
      e_sum  = full[7:0] & mask;
      e_cout = (width_of(sel) == 8) ? full[8] : full[2];
   endtask

   // Present operands for one accept edge. Wait for in_ready first.
   task automatic accept(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
      int waited = 0;
      while (!cur_in_ready && waited < 20) begin
         step();
         waited++;
      end
      check("in_ready_before_accept", cur_in_ready, 1);
      a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("busy_after_accept", cur_busy, 1);
   endtask

   // Count the edges after the accept edge until out_valid rises (bounded).
   task automatic wait_valid(output int edges);
      edges = 0;
      while (!cur_out_valid && edges < 20) begin
         step();
         edges++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("in_ready_after_handshake", cur_in_ready, 1);
      check("out_valid_after_handshake", cur_out_valid, 0);
   endtask

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
      logic [7:0] e_sum;
      logic       e_cout;
      int         edges;
      model(ta, tb_v, tc, e_sum, e_cout);
      accept(ta, tb_v, tc);
      wait_valid(edges);
      check("latency", edges, cycles_of(sel));
      check($sformatf("sum %0h+%0h+%0h", ta, tb_v, tc), cur_sum, e_sum);
      check($sformatf("c_out %0h+%0h+%0h", ta, tb_v, tc), cur_c_out, e_cout);
      handshake();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] e_sum;
      logic       e_cout;
      int         edges;
      bit         seen;

      // Reset state
      rst = 1'b1;
      step();
      step();
      check("rst_in_ready", cur_in_ready, 1);
      check("rst_busy", cur_busy, 0);
      check("rst_out_valid", cur_out_valid, 0);
      check("rst_sum", cur_sum, 0);
      check("rst_c_out", cur_c_out, 0);
      rst = 1'b0;
      step();

      // out_ready while nothing is pending has no effect
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("idle_out_ready_valid", cur_out_valid, 0);
      check("idle_out_ready_in_ready", cur_in_ready, 1);

      // Directed operations, WIDTH=8 DIGIT=2
      sel = 0;
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'hA5, 8'h5A, 1'b1);
      run_op(8'h12, 8'h34, 1'b0);
      run_op(8'hFF, 8'h00, 1'b1);

      // Backpressure: the result holds and new operands are ignored.
      accept(8'h3C, 8'h0F, 1'b1);
      wait_valid(edges);
      check("bp_latency", edges, 4);
      a = 8'h77; b = 8'h11; c_in = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_out_valid", cur_out_valid, 1);
         check("bp_sum", cur_sum, 8'h4C);
         check("bp_c_out", cur_c_out, 0);
         check("bp_in_ready", cur_in_ready, 0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_idle_in_ready", cur_in_ready, 1);
      check("bp_idle_busy", cur_busy, 0);
      step();
      in_valid = 1'b0;
      check("bp_second_accepted", cur_busy, 1);
      wait_valid(edges);
      check("bp2_latency", edges, 4);
      check("bp2_sum", cur_sum, 8'h88);
      check("bp2_c_out", cur_c_out, 0);
      handshake();

      // Reset during the second RUN cycle discards the operation.
      accept(8'hFF, 8'hFF, 1'b1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrun_in_ready", cur_in_ready, 1);
      check("midrun_busy", cur_busy, 0);
      check("midrun_out_valid", cur_out_valid, 0);
      check("midrun_sum", cur_sum, 0);
      check("midrun_c_out", cur_c_out, 0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (cur_out_valid) seen = 1'b1;
      end
      check("midrun_no_result", seen, 0);

      // Randomized, WIDTH=8 DIGIT=2
      for (int i = 0; i < 20; i++) begin
         run_op(8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)));
      end

      // Exhaustive, WIDTH=2 DIGIT=1
      sel = 1;
      for (int ia = 0; ia < 4; ia++) begin
         for (int ib = 0; ib < 4; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               run_op(8'(ia), 8'(ib), 1'(ic));
            end
         end
      end

      // WIDTH=8 DIGIT=8 (N=1)
      sel = 2;
      run_op(8'h80, 8'h80, 1'b0);
      model(8'hFF, 8'h00, 1'b1, e_sum, e_cout);
      accept(8'hFF, 8'h00, 1'b1);
      wait_valid(edges);
      check("n1_wrap_latency", edges, 1);
      check("n1_wrap_sum", cur_sum, e_sum);
      check("n1_wrap_c_out", cur_c_out, e_cout);
      handshake();
      for (int i = 0; i < 10; i++) begin
         run_op(8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Parametrised, multi-cycle successor to the team's 2-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first.
- Operands enter through a valid/ready input handshake; results leave through a valid/ready output handshake.
- Used where a wide single-cycle ripple adder would not meet timing, and as a configurable adder for datapath experiments.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 1.
- DIGIT, 2, bits added per clock; must divide WIDTH exactly (elaboration-time check, $error on violation).
- N (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands a, b, c_in are presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in.
- out_valid  output  1  sum and c_out hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result a+b+c_in, modulo 2^WIDTH.
- c_out  output  1  registered carry-out of the full WIDTH-bit add.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: the first edge with rst=1 sets:
  - state to IDLE;
  - digit counter, carry register, operand and working registers, sum and c_out to 0;
  - out_valid to 0.
  - in_ready=1 and busy=0 after that edge.
  - rst overrides every other input in the same cycle, including mid-RUN and mid-DONE. The in-flight operation is discarded and no result is produced.
- State machine:
  - IDLE: in_ready=1. On in_valid=1, capture a, b into operand registers and c_in into the carry register, clear the counter, go to RUN.
  - RUN: each cycle, for digit slice k=cnt:
    - compute the DIGIT-bit add of a[k], b[k] and the carry register;
    - write the low DIGIT bits into working slice k;
    - store the carry-out into the carry register;
    - increment cnt.
    - On cnt==N-1, after that digit's update, go to DONE.
  - DONE: copy working register to sum and the final carry to c_out on the entry edge; out_valid=1. On out_ready=1, clear out_valid and go to IDLE.
- Latency: operands accepted at edge t. Digits are processed on edges t+1..t+N. out_valid is first high in the cycle after edge t+N. For N=1, out_valid is high after edge t+1.
- Throughput: at most one operation per N+2 cycles. A new accept is possible only in IDLE, at the earliest the cycle after the DONE handshake.
- Inputs while busy: in_ready=0; in_valid, a, b, c_in are ignored and not queued.
- Output stability:
  - sum and c_out change only on DONE entry or reset.
  - They remain stable during backpressure (out_valid=1, out_ready=0) for any number of cycles.
  - They retain the last result through IDLE and RUN, but are meaningful only while out_valid=1.
- out_ready while out_valid=0: no effect.
- Arithmetic: {c_out,sum} == a + b + c_in, computed at WIDTH+1 bits, for all operand values. Wrap-around example: all-ones + 0 + 1 gives sum=0, c_out=1.
- Counter: width $clog2(N) bits, minimum 1. No wrap beyond N-1.

Test Plan:
- WIDTH=8, DIGIT=2: a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1; out_valid first high exactly 4 cycles after the accept edge.
- WIDTH=8, DIGIT=2: a=8'hA5, b=8'h5A, c_in=1 -> sum=8'h00, c_out=1. Then a=8'h12, b=8'h34, c_in=0 -> sum=8'h46, c_out=0.
- Backpressure: hold out_ready=0 for 5 cycles while driving in_valid=1 with a=8'h77 -> out_valid, sum and c_out stable; in_ready=0. The second operand is not accepted until IDLE.
- Reset mid-RUN: assert rst on the 2nd RUN cycle -> next cycle in_ready=1, busy=0, out_valid=0, sum=0; no result is ever emitted for that operation.
- WIDTH=2, DIGIT=1: exhaustive a, b in 0..3, c_in in {0,1} (32 cases) -> every {c_out,sum} == a+b+c_in, each with latency 2.
- WIDTH=8, DIGIT=8 (N=1): a=8'h80, b=8'h80, c_in=0 -> sum=8'h00, c_out=1, out_valid the cycle after edge t+1.
